abs_pipe_mc: RTL and testbench

- Pipelined, multi-channel two's-complement absolute-value unit with a valid/ready handshake.
- Feeds the CORDIC vectoring front end. Its outputs are the magnitude, the original sign (used for quadrant correction) and an overflow flag for the most-negative input.
- Generalises the combinational abs in four ways: N lanes, configurable pipeline depth, selectable saturate/wrap handling of the most-negative value, and a saturating overflow event counter.

---
 rtl/abs_pipe_mc.sv | 113 +++++++++++
 tb/tb_abs_pipe_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/abs_pipe_mc.sv
// abs_pipe_mc: pipelined multi-lane two's-complement absolute value
// with valid/ready flow control and a saturating overflow counter.
module abs_pipe_mc #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int LATENCY    = 2,
    parameter int SAT_MODE   = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CH*WORD_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CH*WORD_WIDTH-1:0]   out_abs,
    output logic [NUM_CH-1:0]              out_sign,
    output logic [NUM_CH-1:0]              out_ovf,
    output logic [CNT_WIDTH-1:0]           ovf_count,
    input  logic                           cnt_clear
);

    localparam int W  = WORD_WIDTH;
    localparam int DW = NUM_CH * W;
    localparam int PW = $clog2(NUM_CH + 1);
    localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  ONE     = W'(1);
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_WIDTH{1'b1}});

    logic              w_adv;
    logic              w_accept;
    logic [DW-1:0]     w_abs;
    logic [NUM_CH-1:0] w_sign;
    logic [NUM_CH-1:0] w_ovf;
    logic [PW-1:0]     w_pop;
    logic [SW-1:0]     w_sum;

    logic [LATENCY-1:0] r_vld;
    logic [DW-1:0]      r_abs  [LATENCY];
    logic [NUM_CH-1:0]  r_sign [LATENCY];
    logic [NUM_CH-1:0]  r_ovf  [LATENCY];
    logic [CNT_WIDTH-1:0] r_cnt;

    assign out_valid = r_vld[LATENCY-1];
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;
    assign w_accept  = in_valid & w_adv;

    // Per-lane magnitude, sign and most-negative detection
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic [W-1:0] w_x;
        assign w_x       = in_data[k*W +: W];
        assign w_sign[k] = w_x[W-1];
        assign w_ovf[k]  = (w_x == MIN_NEG);
        assign w_abs[k*W +: W] =
            w_ovf[k] ? ((SAT_MODE != 0) ? MAX_POS : w_x) :
            w_x[W-1] ? ((~w_x) + ONE) : w_x;
    end

    // Number of overflowing lanes in the incoming beat
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_pop = w_pop + PW'(w_ovf[k]);
        end
    end

    assign w_sum = SW'(r_cnt) + SW'(w_pop);

    // Lock-step shift of every stage, bubbles included
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_abs[i]  <= '0;
                r_sign[i] <= '0;
                r_ovf[i]  <= '0;
            end
        end else if (w_adv) begin
            r_vld     <= {r_vld[LATENCY-1:0], in_valid} >> 0;
            r_abs[0]  <= w_abs;
            r_sign[0] <= w_sign;
            r_ovf[0]  <= w_ovf;
            for (int i = 1; i < LATENCY; i++) begin
                r_abs[i]  <= r_abs[i-1];
                r_sign[i] <= r_sign[i-1];
                r_ovf[i]  <= r_ovf[i-1];
            end
        end
    end

    // Saturating count of overflow lanes on accepted beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clear) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= (w_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}}
                                       : w_sum[CNT_WIDTH-1:0];
        end
    end

    assign out_abs   = r_abs[LATENCY-1];
    assign out_sign  = r_sign[LATENCY-1];
    assign out_ovf   = r_ovf[LATENCY-1];
    assign ovf_count = r_cnt;

endmodule

// File: tb/tb_abs_pipe_mc.sv
// tb_abs_pipe_mc: directed checks of abs_pipe_mc in saturate mode,
// wrap mode and with a 2-bit overflow counter.
module tb_abs_pipe_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        cnt_clear;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_abs;
    logic [1:0]  a_out_sign, a_out_ovf;
    logic [7:0]  a_cnt;

    logic        w_in_ready, w_out_valid;
    logic [31:0] w_out_abs;
    logic [1:0]  w_out_sign, w_out_ovf;
    logic [7:0]  w_cnt;

    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_abs;
    logic [1:0]  c_out_sign, c_out_ovf;
    logic [1:0]  c_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    abs_pipe_mc #(.SAT_MODE(1), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_abs(a_out_abs), .out_sign(a_out_sign), .out_ovf(a_out_ovf),
        .ovf_count(a_cnt), .cnt_clear(cnt_clear));

    abs_pipe_mc #(.SAT_MODE(0), .CNT_WIDTH(8)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_abs(w_out_abs), .out_sign(w_out_sign), .out_ovf(w_out_ovf),
        .ovf_count(w_cnt), .cnt_clear(cnt_clear));

    abs_pipe_mc #(.SAT_MODE(1), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_abs(c_out_abs), .out_sign(c_out_sign), .out_ovf(c_out_ovf),
        .ovf_count(c_cnt), .cnt_clear(cnt_clear));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; cnt_clear = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", a_out_valid);
        else n_pass++;
        n_total++;
        if ({a_out_abs, a_out_sign, a_out_ovf} !== 36'h0)
            $display("FAIL rst_data: got %h %b %b want 0", a_out_abs, a_out_sign, a_out_ovf);
        else n_pass++;
        n_total++;
        if (a_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", a_cnt);
        else n_pass++;
        n_total++;
        if (a_in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", a_in_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'hFF50_0F50;
        step();
        in_valid = 1'b0;
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL single_early: got %b want 0", a_out_valid);
        else n_pass++;
        step();
        n_total++;
        if (a_out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", a_out_valid);
        else n_pass++;
        n_total++;
        if (a_out_abs !== 32'h00B0_0F50) $display("FAIL single_abs: got %h want 00b00f50", a_out_abs);
        else n_pass++;
        n_total++;
        if (a_out_sign !== 2'b10 || a_out_ovf !== 2'b00)
            $display("FAIL single_sign_ovf: got %b %b want 10 00", a_out_sign, a_out_ovf);
        else n_pass++;
        n_total++;
        if (a_cnt !== 8'd0) $display("FAIL single_cnt: got %0d want 0", a_cnt);
        else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vin [5];
        logic [15:0] vexp [5];
        vin  = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'hAAAA, 16'h55A5};
        vexp = '{16'h0001, 16'h7FFF, 16'h0000, 16'h5556, 16'h55A5};
        for (int c = 0; c <= 5; c++) begin
            in_valid = (c < 5);
            in_data  = (c < 5) ? {vin[c], vin[c]} : 32'h0;
            step();
            if (c >= 1) begin
                n_total++;
                if (a_out_valid !== 1'b1 || a_out_abs !== {vexp[c-1], vexp[c-1]})
                    $display("FAIL stream_%0d: got v=%b %h want v=1 %h", c-1,
                             a_out_valid, a_out_abs, {vexp[c-1], vexp[c-1]});
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        step();
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", a_out_valid);
        else n_pass++;
    endtask

    task automatic test_most_negative();
        in_valid = 1'b1; in_data = 32'h8000_8000;
        step();
        in_valid = 1'b0;
        n_total++;
        if (a_cnt !== 8'd2) $display("FAIL mn_cnt: got %0d want 2", a_cnt);
        else n_pass++;
        step();
        n_total++;
        if (a_out_valid !== 1'b1 || a_out_abs !== 32'h7FFF_7FFF || a_out_ovf !== 2'b11)
            $display("FAIL mn_sat: got %b %h %b want 1 7fff7fff 11", a_out_valid, a_out_abs, a_out_ovf);
        else n_pass++;
        n_total++;
        if (w_out_abs !== 32'h8000_8000 || w_out_ovf !== 2'b11 || w_out_sign !== 2'b11)
            $display("FAIL mn_wrap: got %h %b %b want 80008000 11 11", w_out_abs, w_out_ovf, w_out_sign);
        else n_pass++;
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hFFFF_0001;
        step();
        in_data = 32'h0002_FFFE;
        step();
        in_data = 32'hEDCC_1234;
        n_total++;
        if (a_in_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", a_in_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (a_out_valid !== 1'b1 || a_out_abs !== 32'h0001_0001 ||
                a_out_sign !== 2'b10 || a_in_ready !== 1'b0)
                $display("FAIL stall_hold_%0d: got %b %h %b rdy=%b want 1 00010001 10 0",
                         i, a_out_valid, a_out_abs, a_out_sign, a_in_ready);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (a_in_ready !== 1'b1) $display("FAIL stall_release: got %b want 1", a_in_ready);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++;
        if (a_out_valid !== 1'b1 || a_out_abs !== 32'h0002_0002 || a_out_sign !== 2'b01)
            $display("FAIL stall_b1: got %b %h %b want 1 00020002 01", a_out_valid, a_out_abs, a_out_sign);
        else n_pass++;
        step();
        n_total++;
        if (a_out_valid !== 1'b1 || a_out_abs !== 32'h1234_1234 || a_out_sign !== 2'b10)
            $display("FAIL stall_b2: got %b %h %b want 1 12341234 10", a_out_valid, a_out_abs, a_out_sign);
        else n_pass++;
        step();
        n_total++;
        if (a_out_valid !== 1'b0) $display("FAIL stall_end: got %b want 0", a_out_valid);
        else n_pass++;
    endtask

    task automatic test_counter();
        in_valid = 1'b1; in_data = 32'h8000_8000;
        step();
        n_total++;
        if (c_cnt !== 2'd3 || a_cnt !== 8'd4)
            $display("FAIL cnt_sat1: got %0d %0d want 3 4", c_cnt, a_cnt);
        else n_pass++;
        in_data = 32'h0000_8000;
        step();
        n_total++;
        if (c_cnt !== 2'd3 || a_cnt !== 8'd5)
            $display("FAIL cnt_sat2: got %0d %0d want 3 5", c_cnt, a_cnt);
        else n_pass++;
        cnt_clear = 1'b1; in_data = 32'h8000_8000;
        step();
        cnt_clear = 1'b0; in_valid = 1'b0;
        n_total++;
        if (c_cnt !== 2'd0 || a_cnt !== 8'd0 || w_cnt !== 8'd0)
            $display("FAIL cnt_clear: got %0d %0d %0d want 0 0 0", c_cnt, a_cnt, w_cnt);
        else n_pass++;
        step(); step();
    endtask

    task automatic test_reset_inflight();
        in_valid = 1'b1; in_data = 32'h8000_1111;
        step();
        in_data = 32'h8000_2222;
        step();
        in_valid = 1'b0;
        n_total++;
        if (a_cnt !== 8'd2) $display("FAIL rif_pre_cnt: got %0d want 2", a_cnt);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if (a_out_valid !== 1'b0 || a_cnt !== 8'd0)
            $display("FAIL rif_reset: got v=%b cnt=%0d want 0 0", a_out_valid, a_cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (a_out_valid !== 1'b0) $display("FAIL rif_ghost_%0d: got %b want 0", i, a_out_valid);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_most_negative();
        test_stall();
        test_counter();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
